var_cell: RTL and testbench

// - Variable-side endpoint of the lit-cell interface in the clause array.
// - One instance per variable column: receives var_value_o of every lit cell in the column, merges implications,

---
 rtl/sat_pkg.sv | 25 ++
 rtl/var_value_merge.sv | 25 ++
 rtl/var_cell.sv | 140 ++++++++++++++
 tb/tb_var_cell.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared value encodings and variable state type for the clause array
//
// Purpose: common constants and types used by the variable and lit cells.
//   VAL_FREE/VAL_TRUE/VAL_FALSE/VAL_CONF : 2-bit variable value encodings
//   var_state_t                          : variable cell state
package sat_pkg;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_TRUE  = 2'b01;
  localparam logic [1:0] VAL_FALSE = 2'b10;
  localparam logic [1:0] VAL_CONF  = 2'b11;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    DECIDED  = 2'd1,
    IMPLIED  = 2'd2,
    CONFLICT = 2'd3
  } var_state_t;

  // True for a definite (true or false) value.
  function automatic logic is_definite(input logic [1:0] v);
    return (v == VAL_TRUE) || (v == VAL_FALSE);
  endfunction

endpackage

// File: rtl/var_value_merge.sv
// rtl/var_value_merge.sv - OR-merge of the lit cells' value/implication words in one column
//
// Purpose: combinational reduction of every lit cell's {val[1:0], imp} word.
// Ports:
//   var_value_i [3*NUM_LIT-1:0] in  : lit k occupies [3k+2:3k] = {val[1:0], imp}
//   m_o         [1:0]           out : bitwise OR of all val fields
//   imp_any_o                   out : OR of all imp bits
module var_value_merge #(
  parameter int NUM_LIT = 8
) (
  input  logic [3*NUM_LIT-1:0] var_value_i,
  output logic [1:0]           m_o,
  output logic                 imp_any_o
);

  always_comb begin
    m_o       = 2'b00;
    imp_any_o = 1'b0;
    for (int k = 0; k < NUM_LIT; k++) begin
      m_o       = m_o | var_value_i[3*k+1 +: 2];
      imp_any_o = imp_any_o | var_value_i[3*k];
    end
  end

endmodule

// File: rtl/var_cell.sv
// rtl/var_cell.sv - variable-side endpoint of the lit-cell interface for one variable column
//
// Purpose: merges implications from the column's lit cells, detects opposite-polarity
// conflicts and holds the variable's value, decision level and implied flag.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   var_value_i [3*NUM_LIT-1:0]  : lit cells' {val[1:0], imp} words
//   var_value_o [2:0]            : registered {value, implied} broadcast to lit cells
//   decide_i, decide_value_i     : decision strobe and decided value
//   cur_level_i                  : level stamped on decide/imply
//   imp_en_i                     : take the merged implications this cycle
//   backtrack_i, bkt_level_i     : backtrack strobe and target level
//   wr_i, value_i, level_i, implied_i : direct load (bin swap-in)
//   level_o, assigned_o, conflict_o   : stored level, DECIDED/IMPLIED, CONFLICT
module var_cell
  import sat_pkg::*;
#(
  parameter int NUM_LIT = 8,
  parameter int LEVEL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*NUM_LIT-1:0] var_value_i,
  output logic [2:0]           var_value_o,
  input  logic                 decide_i,
  input  logic [1:0]           decide_value_i,
  input  logic [LEVEL_W-1:0]   cur_level_i,
  input  logic                 imp_en_i,
  input  logic                 backtrack_i,
  input  logic [LEVEL_W-1:0]   bkt_level_i,
  input  logic                 wr_i,
  input  logic [1:0]           value_i,
  input  logic [LEVEL_W-1:0]   level_i,
  input  logic                 implied_i,
  output logic [LEVEL_W-1:0]   level_o,
  output logic                 assigned_o,
  output logic                 conflict_o
);

  var_state_t         state_q, state_d;
  logic [1:0]         value_q, value_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               implied_q, implied_d;

  logic [1:0] m;
  logic       imp_any;

  var_value_merge #(
    .NUM_LIT (NUM_LIT)
  ) u_merge (
    .var_value_i (var_value_i),
    .m_o         (m),
    .imp_any_o   (imp_any)
  );

  // One event per cycle, in priority order. A strobe that is asserted but has
  // no effect in the current state still claims the cycle.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    level_d   = level_q;
    implied_d = implied_q;

    if (wr_i) begin
      if (is_definite(value_i)) begin
        state_d   = implied_i ? IMPLIED : DECIDED;
        value_d   = value_i;
        level_d   = level_i;
        implied_d = implied_i;
      end else begin
        // Free or illegal conflict load: enter FREE with all fields cleared.
        state_d   = FREE;
        value_d   = VAL_FREE;
        level_d   = '0;
        implied_d = 1'b0;
      end
    end else if (backtrack_i) begin
      if ((state_q == CONFLICT) ||
          ((state_q != FREE) && (level_q > bkt_level_i))) begin
        state_d   = FREE;
        value_d   = VAL_FREE;
        level_d   = '0;
        implied_d = 1'b0;
      end
    end else if (decide_i) begin
      if ((state_q == FREE) && is_definite(decide_value_i)) begin
        state_d   = DECIDED;
        value_d   = decide_value_i;
        level_d   = cur_level_i;
        implied_d = 1'b0;
      end
    end else if (imp_en_i && imp_any) begin
      case (state_q)
        FREE: begin
          if (m == VAL_CONF) begin
            state_d   = CONFLICT;
            value_d   = VAL_CONF;
            level_d   = cur_level_i;
            implied_d = 1'b1;
          end else if (m != VAL_FREE) begin
            state_d   = IMPLIED;
            value_d   = m;
            level_d   = cur_level_i;
            implied_d = 1'b1;
          end
        end
        DECIDED, IMPLIED: begin
          // An implication of the opposite polarity to the held value.
          if ((m & ~value_q) != 2'b00) begin
            state_d = CONFLICT;
            value_d = VAL_CONF;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      value_q   <= VAL_FREE;
      level_q   <= '0;
      implied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      level_q   <= level_d;
      implied_q <= implied_d;
    end
  end

  // Outputs decode registers only, so var_value_i never reaches var_value_o
  // combinationally.
  assign var_value_o = {value_q, implied_q};
  assign level_o     = level_q;
  assign assigned_o  = (state_q == DECIDED) || (state_q == IMPLIED);
  assign conflict_o  = (state_q == CONFLICT);

endmodule

// File: tb/tb_var_cell.sv
// tb/tb_var_cell.sv - scoreboard testbench for var_cell with a behavioural reference model
module tb_var_cell;

  localparam int NL = 8;
  localparam int LW = 8;

  localparam int S_FREE = 0;
  localparam int S_DEC  = 1;
  localparam int S_IMP  = 2;
  localparam int S_CONF = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3*NL-1:0] var_value_i;
  logic [2:0]    var_value_o;
  logic          decide_i;
  logic [1:0]    decide_value_i;
  logic [LW-1:0] cur_level_i;
  logic          imp_en_i;
  logic          backtrack_i;
  logic [LW-1:0] bkt_level_i;
  logic          wr_i;
  logic [1:0]    value_i;
  logic [LW-1:0] level_i;
  logic          implied_i;
  logic [LW-1:0] level_o;
  logic          assigned_o;
  logic          conflict_o;

  logic [2:0] lit [NL];

  always #5 clk = ~clk;

  always_comb begin
    var_value_i = '0;
    for (int k = 0; k < NL; k++) var_value_i[3*k +: 3] = lit[k];
  end

  var_cell #(.NUM_LIT(NL), .LEVEL_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .var_value_i    (var_value_i),
    .var_value_o    (var_value_o),
    .decide_i       (decide_i),
    .decide_value_i (decide_value_i),
    .cur_level_i    (cur_level_i),
    .imp_en_i       (imp_en_i),
    .backtrack_i    (backtrack_i),
    .bkt_level_i    (bkt_level_i),
    .wr_i           (wr_i),
    .value_i        (value_i),
    .level_i        (level_i),
    .implied_i      (implied_i),
    .level_o        (level_o),
    .assigned_o     (assigned_o),
    .conflict_o     (conflict_o)
  );

  // Expected outputs: {var_value_o, level_o, assigned_o, conflict_o}
  logic [12:0] exp_q [$];
  string       name_q [$];
  int passed = 0;
  int total  = 0;

  // Reference model of the variable
  int         ms = S_FREE;
  logic [1:0] mv = 2'b00;
  logic [LW-1:0] ml = '0;
  logic       mi = 1'b0;

  task automatic model_clear();
    ms = S_FREE; mv = 2'b00; ml = '0; mi = 1'b0;
  endtask

  // Apply the current inputs for one clock: update model, queue expectation.
  task automatic apply(input string name);
    logic [1:0] m;
    logic       ia;
    m = 2'b00;
    ia = 1'b0;
    for (int k = 0; k < NL; k++) begin
      m  = m | lit[k][2:1];
      ia = ia | lit[k][0];
    end
    if (rst) begin
      model_clear();
    end else if (wr_i) begin
      if (value_i == 2'b01 || value_i == 2'b10) begin
        ms = implied_i ? S_IMP : S_DEC;
        mv = value_i; ml = level_i; mi = implied_i;
      end else begin
        model_clear();
      end
    end else if (backtrack_i) begin
      if (ms == S_CONF) model_clear();
      else if (ms != S_FREE && ml > bkt_level_i) model_clear();
    end else if (decide_i) begin
      if (ms == S_FREE && (decide_value_i == 2'b01 || decide_value_i == 2'b10)) begin
        ms = S_DEC; mv = decide_value_i; ml = cur_level_i; mi = 1'b0;
      end
    end else if (imp_en_i && ia) begin
      if (ms == S_FREE) begin
        if (m == 2'b11) begin
          ms = S_CONF; mv = 2'b11; ml = cur_level_i; mi = 1'b1;
        end else if (m != 2'b00) begin
          ms = S_IMP; mv = m; ml = cur_level_i; mi = 1'b1;
        end
      end else if (ms != S_CONF && (m & ~mv) != 2'b00) begin
        ms = S_CONF; mv = 2'b11;
      end
    end
    exp_q.push_back({mv, mi, ml, (ms == S_DEC || ms == S_IMP), (ms == S_CONF)});
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; decide_i = 1'b0; decide_value_i = 2'b00; cur_level_i = '0;
    imp_en_i = 1'b0; backtrack_i = 1'b0; bkt_level_i = '0;
    wr_i = 1'b0; value_i = 2'b00; level_i = '0; implied_i = 1'b0;
    for (int k = 0; k < NL; k++) lit[k] = 3'b000;
  endtask

  // Monitor: every expectation is due right after the next rising edge.
  initial begin
    logic [12:0] e;
    logic [12:0] got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {var_value_o, level_o, assigned_o, conflict_o};
        total++;
        if (got === e) passed++;
        else $display("FAIL %s: got vv=%b lvl=%0d asg=%b conf=%b, expected vv=%b lvl=%0d asg=%b conf=%b",
                      nm, got[12:10], got[9:2], got[1], got[0], e[12:10], e[9:2], e[1], e[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    idle();
    rst = 1'b1;
    @(negedge clk);

    // Reset with every lit driving 011 and implications enabled
    for (int k = 0; k < NL; k++) lit[k] = 3'b011;
    imp_en_i = 1'b1; cur_level_i = 8'd9;
    apply("reset_c1");
    apply("reset_c2");
    idle();
    apply("after_reset");

    // Decide then backtrack
    decide_i = 1'b1; decide_value_i = 2'b01; cur_level_i = 8'd3;
    apply("decide_true_l3");
    idle(); backtrack_i = 1'b1; bkt_level_i = 8'd3;
    apply("backtrack_to_3_holds");
    bkt_level_i = 8'd2;
    apply("backtrack_to_2_frees");

    // Single implication from lit 5, then a decide that must be ignored
    idle(); lit[5] = 3'b101; imp_en_i = 1'b1; cur_level_i = 8'd4;
    apply("imply_false_l4");
    idle(); decide_i = 1'b1; decide_value_i = 2'b01; cur_level_i = 8'd7;
    apply("decide_ignored_implied");
    idle(); backtrack_i = 1'b1; bkt_level_i = 8'd0;
    apply("backtrack_to_0");

    // Opposite-polarity implications
    idle(); lit[0] = 3'b011; lit[7] = 3'b101; imp_en_i = 1'b1; cur_level_i = 8'd6;
    apply("conflict_l6");
    idle(); imp_en_i = 1'b1; lit[2] = 3'b011;
    apply("conflict_holds");
    idle(); backtrack_i = 1'b1; bkt_level_i = 8'd6;
    apply("conflict_backtrack");

    // Load wins over backtrack and decide
    idle(); wr_i = 1'b1; value_i = 2'b10; level_i = 8'd2; implied_i = 1'b1;
    decide_i = 1'b1; decide_value_i = 2'b01; backtrack_i = 1'b1; bkt_level_i = 8'd0;
    apply("wr_priority");
    idle(); wr_i = 1'b1; value_i = 2'b11; level_i = 8'd5; implied_i = 1'b1;
    apply("wr_illegal_11");

    // Implication against a held decision
    idle(); decide_i = 1'b1; decide_value_i = 2'b10; cur_level_i = 8'd1;
    apply("decide_false_l1");
    idle(); lit[3] = 3'b011; imp_en_i = 1'b1; cur_level_i = 8'd8;
    apply("decided_then_conflict");

    // Reset wins over an implication while in conflict
    idle(); rst = 1'b1; lit[1] = 3'b101; imp_en_i = 1'b1; cur_level_i = 8'd5;
    apply("reset_mid_conflict");
    idle();
    apply("after_mid_reset");

    // Randomized traffic: at most one strobe per cycle
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < NL; k++) begin
        r = $urandom_range(0, 7);
        if (r == 0) lit[k] = 3'b011;
        else if (r == 1) lit[k] = 3'b101;
        else if (r == 2) lit[k] = 3'b001;
      end
      imp_en_i    = $urandom_range(0, 1);
      cur_level_i = LW'($urandom_range(0, 7));
      r = $urandom_range(0, 19);
      if (r == 0) rst = 1'b1;
      else if (r <= 2) begin
        wr_i = 1'b1; value_i = 2'($urandom_range(0, 3));
        level_i = LW'($urandom_range(0, 7)); implied_i = 1'($urandom_range(0, 1));
      end else if (r <= 5) begin
        backtrack_i = 1'b1; bkt_level_i = LW'($urandom_range(0, 7));
      end else if (r <= 9) begin
        decide_i = 1'b1; decide_value_i = 2'($urandom_range(0, 3));
      end
      apply("random");
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
